// File: rtl/multi_timer_peripheral.sv
// rtl/multi_timer_peripheral.sv - memory-mapped reload timers with LED, switch and 7-segment digit registers
// Optional macro PERIPH_SWITCH_SYNC_EN: passes the switch inputs through a 2-flop synchronizer.
module multi_timer_peripheral #(
    parameter logic [31:0] BASE_ADDR  = 32'h40000000,
    parameter int          NUM_TIMERS = 2,
    parameter int          TIMER_W    = 32,
    parameter int          PRESC_W    = 16,
    parameter int          LED_W      = 8,
    parameter int          SW_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [LED_W-1:0]  led,
    input  logic [SW_W-1:0]   switch,
    output logic [11:0]       digi,
    output logic              irqout
);

    logic [TIMER_W-1:0]    th    [NUM_TIMERS];
    logic [TIMER_W-1:0]    tl    [NUM_TIMERS];
    logic [PRESC_W-1:0]    presc [NUM_TIMERS];
    logic [PRESC_W-1:0]    pc    [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] en, ie, pend, oneshot;

    logic [7:0]            off;
    logic [4:0]            ch_idx;
    logic                  in_window;
    logic                  ch_hit;
    logic [NUM_TIMERS-1:0] wr_th, wr_tl, wr_tcon, wr_presc;
    logic [NUM_TIMERS-1:0] tick, ovf;
    logic [SW_W-1:0]       sw_val;
    logic [31:0]           rd_val;

    assign off       = addr[7:0];
    assign ch_idx    = off[6:2];
    assign in_window = (addr[31:8] == BASE_ADDR[31:8]);
    assign ch_hit    = in_window && !off[7] && (32'(ch_idx) < NUM_TIMERS);

    // Per-channel write strobes plus prescaler tick and overflow detection
    always_comb begin
        wr_th    = '0;
        wr_tl    = '0;
        wr_tcon  = '0;
        wr_presc = '0;
        tick     = '0;
        ovf      = '0;
        for (int k = 0; k < NUM_TIMERS; k++) begin
            if (wr && ch_hit && (ch_idx == k[4:0])) begin
                case (off[1:0])
                    2'd0:    wr_th[k]    = 1'b1;
                    2'd1:    wr_tl[k]    = 1'b1;
                    2'd2:    wr_tcon[k]  = 1'b1;
                    default: wr_presc[k] = 1'b1;
                endcase
            end
            tick[k] = en[k] && (pc[k] == presc[k]);
            ovf[k]  = tick[k] && (&tl[k]);
        end
    end

    // Timer channel state: bus writes, prescaler, count/reload, pending and one-shot stop
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_TIMERS; k++) begin
                th[k]    <= '0;
                tl[k]    <= '0;
                presc[k] <= '0;
                pc[k]    <= '0;
            end
            en      <= '0;
            ie      <= '0;
            pend    <= '0;
            oneshot <= '0;
        end else begin
            for (int k = 0; k < NUM_TIMERS; k++) begin
                if (wr_th[k])
                    th[k] <= wdata[TIMER_W-1:0];
                // a bus write to TL wins over the count; the reload uses the pre-write TH
                if (wr_tl[k])
                    tl[k] <= wdata[TIMER_W-1:0];
                else if (ovf[k])
                    tl[k] <= th[k];
                else if (tick[k])
                    tl[k] <= tl[k] + TIMER_W'(1);
                if (wr_presc[k])
                    presc[k] <= wdata[PRESC_W-1:0];
                if (wr_presc[k] || wr_tcon[k] || !en[k] || tick[k])
                    pc[k] <= '0;
                else
                    pc[k] <= pc[k] + PRESC_W'(1);
                if (wr_tcon[k]) begin
                    ie[k]      <= wdata[1];
                    oneshot[k] <= wdata[3];
                end
                if (ovf[k] && oneshot[k])
                    en[k] <= 1'b0;
                else if (wr_tcon[k])
                    en[k] <= wdata[0];
                // a fresh overflow beats a simultaneous write-1-to-clear
                if (ovf[k] && ie[k])
                    pend[k] <= 1'b1;
                else if (wr_tcon[k] && wdata[2])
                    pend[k] <= 1'b0;
            end
        end
    end

    // LED and digit output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            led  <= '0;
            digi <= '0;
        end else if (wr && in_window) begin
            if (off == 8'hF0)
                led <= wdata[LED_W-1:0];
            if (off == 8'hF2)
                digi <= wdata[11:0];
        end
    end

`ifdef PERIPH_SWITCH_SYNC_EN
    logic [SW_W-1:0] sw_s1, sw_s2;

    // Two-stage synchronizer for the asynchronous switch inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= switch;
            sw_s2 <= sw_s1;
        end
    end

    assign sw_val = sw_s2;
`else
    assign sw_val = switch;
`endif

    // Read multiplexer; narrower registers are zero-extended
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_TIMERS; k++) begin
            if (ch_hit && (ch_idx == k[4:0])) begin
                case (off[1:0])
                    2'd0:    rd_val[TIMER_W-1:0] = th[k];
                    2'd1:    rd_val[TIMER_W-1:0] = tl[k];
                    2'd2:    rd_val[3:0]         = {oneshot[k], pend[k], ie[k], en[k]};
                    default: rd_val[PRESC_W-1:0] = presc[k];
                endcase
            end
        end
        if (in_window) begin
            case (off)
                8'hF0:   rd_val[LED_W-1:0]      = led;
                8'hF1:   rd_val[SW_W-1:0]       = sw_val;
                8'hF2:   rd_val[11:0]           = digi;
                8'hF3:   rd_val[NUM_TIMERS-1:0] = pend;
                default: ;
            endcase
        end
    end

    // Registered read data; a combined rd+wr cycle performs only the write
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else if (rd && !wr)
            rdata <= rd_val;
    end

    assign irqout = |pend;

endmodule

// File: tb/tb_multi_timer_peripheral.sv
// tb/tb_multi_timer_peripheral.sv - randomized and directed bench with behavioural reference model
module tb_multi_timer_peripheral;

    localparam int          NT   = 2;
    localparam logic [31:0] BASE = 32'h40000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic [7:0]  switch = '0;
    logic [11:0] digi;
    logic        irqout;

    always #5 clk = ~clk;

    multi_timer_peripheral dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .led    (led),
        .switch (switch),
        .digi   (digi),
        .irqout (irqout)
    );

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [31:0] m_th [NT];
    logic [31:0] m_tl [NT];
    logic [31:0] m_presc [NT];
    int          m_pc [NT];
    bit          m_en [NT];
    bit          m_ie [NT];
    bit          m_pend [NT];
    bit          m_one [NT];
    logic [31:0] m_rdata = '0;
    logic [7:0]  m_led = '0;
    logic [11:0] m_digi = '0;
    logic [7:0]  m_sw1 = '0;
    logic [7:0]  m_sw2 = '0;
    bit          m_valid = 1'b0;

    function automatic bit m_irq();
        bit r = 1'b0;
        for (int k = 0; k < NT; k++) r |= m_pend[k];
        return r;
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] a);
        int o = int'(a[7:0]);
        logic [31:0] v = '0;
        if (a[31:8] != BASE[31:8]) return 32'h0;
        if (o < 4 * NT) begin
            case (o % 4)
                0: return m_th[o / 4];
                1: return m_tl[o / 4];
                2: return {28'h0, m_one[o / 4], m_pend[o / 4], m_ie[o / 4], m_en[o / 4]};
                default: return m_presc[o / 4];
            endcase
        end
        case (o)
            'hF0: return {24'h0, m_led};
`ifdef PERIPH_SWITCH_SYNC_EN
            'hF1: return {24'h0, m_sw2};
`else
            'hF1: return {24'h0, switch};
`endif
            'hF2: return {20'h0, m_digi};
            'hF3: begin
                for (int k = 0; k < NT; k++) v[k] = m_pend[k];
                return v;
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        bit win = (addr[31:8] == BASE[31:8]);
        int o = int'(addr[7:0]);
        bit tick, ovf, wth, wtl, wtc, wps;
        if (reset) begin
            for (int k = 0; k < NT; k++) begin
                m_th[k] = 0; m_tl[k] = 0; m_presc[k] = 0; m_pc[k] = 0;
                m_en[k] = 0; m_ie[k] = 0; m_pend[k] = 0; m_one[k] = 0;
            end
            m_rdata = 0; m_led = 0; m_digi = 0; m_sw1 = 0; m_sw2 = 0;
            m_valid = 1'b1;
            return;
        end
        if (rd && !wr) m_rdata = m_read(addr);
        for (int k = 0; k < NT; k++) begin
            wth  = wr && win && (o == 4 * k);
            wtl  = wr && win && (o == 4 * k + 1);
            wtc  = wr && win && (o == 4 * k + 2);
            wps  = wr && win && (o == 4 * k + 3);
            tick = m_en[k] && (m_pc[k] == int'(m_presc[k]));
            ovf  = tick && (m_tl[k] == 32'hFFFF_FFFF);
            m_pc[k] = (wps || wtc || !m_en[k] || tick) ? 0 : m_pc[k] + 1;
            if (wtl)       m_tl[k] = wdata;
            else if (ovf)  m_tl[k] = m_th[k];
            else if (tick) m_tl[k] = m_tl[k] + 1;
            if (wth) m_th[k] = wdata;
            if (wps) m_presc[k] = {16'h0, wdata[15:0]};
            if (wtc && wdata[2]) m_pend[k] = 0;
            if (ovf && m_ie[k])  m_pend[k] = 1;
            if (wtc) m_en[k] = wdata[0];
            if (ovf && m_one[k]) m_en[k] = 0;
            if (wtc) begin m_ie[k] = wdata[1]; m_one[k] = wdata[3]; end
        end
        if (wr && win && o == 'hF0) m_led = wdata[7:0];
        if (wr && win && o == 'hF2) m_digi = wdata[11:0];
        m_sw2 = m_sw1;
        m_sw1 = switch;
    endtask

    always @(posedge clk) model_step();

    // cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if (rdata !== m_rdata || led !== m_led || digi !== m_digi || irqout !== m_irq()) begin
                miscompares++;
                $display("FAIL cycle_compare t=%0t: rdata=%h/%h led=%h/%h digi=%h/%h irq=%b/%b (got/required)",
                         $time, rdata, m_rdata, led, m_led, digi, m_digi, irqout, m_irq());
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic op(bit r, bit w, logic [31:0] a, logic [31:0] d);
        rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic wreg(logic [7:0] o, logic [31:0] d);
        op(1'b0, 1'b1, BASE + {24'h0, o}, d);
    endtask

    task automatic rreg(logic [7:0] o);
        op(1'b1, 1'b0, BASE + {24'h0, o}, 32'h0);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    logic [7:0] offs [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                              8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'h80, 8'h7F};

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset sequence
        wreg(8'h00, 32'h5);
        wreg(8'h02, 32'h3);
        pulse_reset();
        rreg(8'h00); check("rst_th0", rdata, 32'h0);
        rreg(8'h01); check("rst_tl0", rdata, 32'h0);
        rreg(8'h02); check("rst_tcon0", rdata, 32'h0);
        rreg(8'hF0); check("rst_led", rdata, 32'h0);
        check("rst_irq", {31'h0, irqout}, 32'h0);

        // periodic wrap, W1C and overflow-vs-clear priority
        wreg(8'h00, 32'hFFFF_FFFD);
        wreg(8'h01, 32'hFFFF_FFFD);
        wreg(8'h03, 32'h0);
        wreg(8'h02, 32'h3);
        rreg(8'h01); check("wrap_tl_a", rdata, 32'hFFFF_FFFD);
        rreg(8'h01); check("wrap_tl_b", rdata, 32'hFFFF_FFFE);
        check("wrap_irq_before", {31'h0, irqout}, 32'h0);
        rreg(8'h01); check("wrap_tl_c", rdata, 32'hFFFF_FFFF);
        check("wrap_irq_after", {31'h0, irqout}, 32'h1);
        rreg(8'h01); check("wrap_tl_d", rdata, 32'hFFFF_FFFD);
        wreg(8'h02, 32'h7); check("w1c_clear", {31'h0, irqout}, 32'h0);
        wreg(8'h02, 32'h7); check("w1c_vs_ovf", {31'h0, irqout}, 32'h1);
        wreg(8'h02, 32'h4);
        rreg(8'h02); check("tcon0_off", rdata, 32'h0);

        // prescaler and one-shot on channel 1
        wreg(8'h07, 32'h3);
        wreg(8'h04, 32'hFFFF_FFFE);
        wreg(8'h05, 32'hFFFF_FFFE);
        wreg(8'h06, 32'hB);
        idle(); idle();
        rreg(8'h05); check("presc_tl_a", rdata, 32'hFFFF_FFFE);
        rreg(8'h05); check("presc_tl_b", rdata, 32'hFFFF_FFFE);
        rreg(8'h05); check("presc_tl_c", rdata, 32'hFFFF_FFFF);
        idle(); idle(); idle();
        rreg(8'h06); check("oneshot_tcon1", rdata, 32'hE);
        rreg(8'h05); check("oneshot_tl1", rdata, 32'hFFFF_FFFE);

        // IRQ_VEC, and TCON write with EN=0 on an overflow cycle
        wreg(8'h00, 32'hFFFF_FFFF);
        wreg(8'h01, 32'hFFFF_FFFF);
        wreg(8'h02, 32'h3);
        idle();
        wreg(8'h02, 32'h2);
        rreg(8'hF3); check("irqvec_both", rdata, 32'h3);
        rreg(8'h02); check("tcon0_en0_pend", rdata, 32'h6);
        wreg(8'h02, 32'h4);
        rreg(8'hF3); check("irqvec_ch1", rdata, 32'h2);
        check("irq_ch1_only", {31'h0, irqout}, 32'h1);
        pulse_reset();
        check("irq_after_reset", {31'h0, irqout}, 32'h0);

        // map and read timing
        wreg(8'hF0, 32'hA5);
        wreg(8'hF2, 32'h3C1);
        rreg(8'hF0); check("led_rd", rdata, 32'hA5);
        rreg(8'hF2); check("digi_rd", rdata, 32'h3C1);
        rreg(8'h80); check("unmapped_rd", rdata, 32'h0);
        rreg(8'hF0);
        op(1'b1, 1'b0, 32'h4000_01F0, 32'h0); check("out_window_rd", rdata, 32'h0);
        rreg(8'hF0);
        op(1'b1, 1'b1, BASE + 32'hF0, 32'h5A); check("rdwr_hold", rdata, 32'hA5);
        check("rdwr_led", {24'h0, led}, 32'h5A);
        switch = 8'h3C;
        idle(); idle();
        rreg(8'hF1); check("switch_rd", rdata, 32'h3C);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int sel = $urandom_range(0, 14);
            logic [31:0] a, d;
            bit r, w;
            if (sel == 14) a = 32'h5000_0000 | 32'($urandom_range(0, 255));
            else a = BASE + {24'h0, offs[sel]};
            d = $urandom;
            if (sel < 8) begin
                case (sel % 4)
                    0, 1: if ($urandom_range(0, 3) != 0) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                    2: d = 32'($urandom_range(0, 15));
                    default: d = 32'($urandom_range(0, 3));
                endcase
            end
            r = ($urandom_range(0, 1) == 1);
            w = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) switch = 8'($urandom);
            if ($urandom_range(0, 299) == 0) pulse_reset();
            else op(r, w, a, d);
        end

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
